// File: rtl/rv32i_pkg.sv
// Shared types for the memory arbiter: owner tags, FSM states and the
// default starvation limit.
package rv32i_pkg;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } MemOwner_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RSP
  } MemArbState_e;

  localparam int unsigned MEM_ARB_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, LSU and shared-memory handshakes around mem_arbiter.
// slave = the arbiter's view, master = requesters plus memory.
interface mem_arbiter_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;

  logic        i_ls_req;
  logic        i_ls_we;
  logic [3:0]  i_ls_be;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;

  logic        o_mem_req;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  logic        o_busy;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_busy
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_busy
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Priority pick between fetch and LSU: LSU first, but fetch is forced through
// after STARVE_MAX consecutive LSU wins while it waits.
module mem_arb_pick
  import rv32i_pkg::*;
#(
  parameter int unsigned STARVE_MAX = MEM_ARB_STARVE_MAX
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      arb_en_i,
  input  logic      if_req_i,
  input  logic      ls_req_i,
  output logic      pick_vld_o,
  output MemOwner_e pick_own_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic       ls_win;

  always_comb begin
    ls_win     = ls_req_i && ((starve_q < STARVE_LIM) || !if_req_i);
    pick_vld_o = ls_win || if_req_i;
    pick_own_o = ls_win ? OWN_LS : OWN_IF;

    starve_d = starve_q;
    if (arb_en_i && pick_vld_o) begin
      // Only LSU wins over a waiting fetch count; any other grant resets.
      if (ls_win && if_req_i) begin
        starve_d = (starve_q < STARVE_LIM) ? starve_q + 4'd1 : starve_q;
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction
// fetch and the LSU; request fields are latched at selection.
module mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned STARVE_MAX = MEM_ARB_STARVE_MAX
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.slave  bus
);

  MemArbState_e state_q;
  MemOwner_e    owner_q;
  logic         we_q;
  logic [3:0]   be_q;
  logic [31:0]  addr_q;
  logic [31:0]  wdata_q;

  logic         arb_en;
  logic         pick_vld;
  MemOwner_e    pick_own;
  logic         rsp_hit;

  // Re-arbitration also happens on the response beat so back-to-back
  // transactions skip IDLE.
  assign arb_en  = (state_q == ARB_IDLE) || ((state_q == ARB_RSP) && bus.i_mem_rvalid);
  assign rsp_hit = (state_q == ARB_RSP) && bus.i_mem_rvalid;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .arb_en_i   (arb_en),
    .if_req_i   (bus.i_if_req),
    .ls_req_i   (bus.i_ls_req),
    .pick_vld_o (pick_vld),
    .pick_own_o (pick_own)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE, ARB_RSP: begin
          if (arb_en) begin
            if (pick_vld) begin
              state_q <= ARB_REQ;
              owner_q <= pick_own;
              if (pick_own == OWN_LS) begin
                we_q    <= bus.i_ls_we;
                be_q    <= bus.i_ls_be;
                addr_q  <= bus.i_ls_addr;
                wdata_q <= bus.i_ls_wdata;
              end else begin
                we_q    <= 1'b0;
                be_q    <= '1;
                addr_q  <= bus.i_if_addr;
                wdata_q <= '0;
              end
            end else begin
              state_q <= ARB_IDLE;
            end
          end
        end
        ARB_REQ: begin
          if (bus.i_mem_gnt) begin
            state_q <= ARB_RSP;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.o_mem_req   = (state_q == ARB_REQ);
  assign bus.o_mem_we    = we_q;
  assign bus.o_mem_be    = be_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_busy      = (state_q != ARB_IDLE);

  assign bus.o_if_gnt    = bus.o_mem_req && (owner_q == OWN_IF) && bus.i_mem_gnt;
  assign bus.o_ls_gnt    = bus.o_mem_req && (owner_q == OWN_LS) && bus.i_mem_gnt;
  assign bus.o_if_rvalid = rsp_hit && (owner_q == OWN_IF);
  assign bus.o_ls_rvalid = rsp_hit && (owner_q == OWN_LS);
  assign bus.o_if_rdata  = bus.o_if_rvalid ? bus.i_mem_rdata : '0;
  assign bus.o_ls_rdata  = bus.o_ls_rvalid ? bus.i_mem_rdata : '0;

endmodule
